// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared types and constants for the ID-stage hazard controller
package mips_hazard_pkg;
    typedef enum logic {
        IDLE     = 1'b0,
        RESERVED = 1'b1
    } rsv_state_e;
    localparam int REG_ZERO    = 0;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_AW  = 5;
    localparam int DEF_NUM_FWD = 2;
    localparam int DEF_MD_LAT  = 4;
    localparam int DEF_CNT_W   = 32;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority forwarding mux and not-ready flag for one operand
module fwd_select
    import mips_hazard_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int NUM_FWD = DEF_NUM_FWD
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic                      reads,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    output logic [DATA_W-1:0]         data,
    output logic                      hazard
);
    // walk oldest to youngest so the youngest matching stage overrides
    always_comb begin
        data   = rf_data;
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_addr[i*REG_AW +: REG_AW] == addr && addr != REG_AW'(REG_ZERO)) begin
                data   = fwd_data[i*DATA_W +: DATA_W];
                hazard = reads & ~fwd_ready[i];
            end
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage forwarding, stall, mul/div busy and LL/SC reservation control
module hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int NUM_FWD = DEF_NUM_FWD,
    parameter int MD_LAT  = DEF_MD_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rs_addr,
    input  logic [REG_AW-1:0]         id_rt_addr,
    input  logic                      id_reads_rs,
    input  logic                      id_reads_rt,
    input  logic [DATA_W-1:0]         rf_rs_data,
    input  logic [DATA_W-1:0]         rf_rt_data,
    input  logic                      id_is_md,
    input  logic                      id_reads_hilo,
    input  logic                      id_is_ll,
    input  logic                      id_is_sc,
    input  logic                      id_is_store,
    input  logic                      flush,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data,
    output logic                      stall,
    output logic                      md_busy,
    output logic                      atomic,
    output logic                      sc_mask,
    output logic [CNT_W-1:0]          stall_cycles
);
    localparam int MD_W = $clog2(MD_LAT + 1);

    logic [MD_W-1:0] md_cnt;
    rsv_state_e      state, state_n;
    logic            rs_haz, rt_haz, issue;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs (
        .addr(id_rs_addr), .reads(id_reads_rs), .rf_data(rf_rs_data),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .data(rs_data), .hazard(rs_haz)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rt (
        .addr(id_rt_addr), .reads(id_reads_rt), .rf_data(rf_rt_data),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .data(rt_data), .hazard(rt_haz)
    );

    assign md_busy = md_cnt != '0;
    assign stall   = id_valid & ~flush & (rs_haz | rt_haz | (md_busy & (id_is_md | id_reads_hilo)));
    assign issue   = id_valid & ~stall & ~flush;
    assign atomic  = state == RESERVED;
    assign sc_mask = id_valid & id_is_sc & ~atomic;

    // HI/LO occupancy countdown and saturating stall counter; flush does not cancel a running mul/div
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            if (issue && id_is_md) md_cnt <= MD_W'(MD_LAT);
            else if (md_busy)      md_cnt <= md_cnt - MD_W'(1);
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // reservation state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // reservation next state: flush wins, then issued LL sets, issued SC or store clears
    always_comb begin
        state_n = state;
        if (flush)                                 state_n = IDLE;
        else if (issue && id_is_ll)                state_n = RESERVED;
        else if (issue && (id_is_sc || id_is_store)) state_n = IDLE;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_FWD = 2;
    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_reads_rs, id_reads_rt, id_is_md, id_reads_hilo;
    logic id_is_ll, id_is_sc, id_is_store, flush;
    logic [REG_AW-1:0] id_rs_addr, id_rt_addr;
    logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
    logic [NUM_FWD-1:0] fwd_we, fwd_ready;
    logic [NUM_FWD*REG_AW-1:0] fwd_addr;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic stall, md_busy, atomic, sc_mask;
    logic [CNT_W-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
        .id_is_ll(id_is_ll), .id_is_sc(id_is_sc), .id_is_store(id_is_store),
        .flush(flush), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_ready(fwd_ready), .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .md_busy(md_busy), .atomic(atomic), .sc_mask(sc_mask),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_reads_rs = 0; id_reads_rt = 0; id_is_md = 0; id_reads_hilo = 0;
        id_is_ll = 0; id_is_sc = 0; id_is_store = 0; flush = 0;
        id_rs_addr = 0; id_rt_addr = 0; rf_rs_data = 0; rf_rt_data = 0;
        fwd_we = 0; fwd_ready = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        clr();
        id_valid = 1; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_data = {32'h0, 32'h9999};
        fwd_ready = 2'b00; id_rt_addr = 9; id_reads_rt = 1; rf_rt_data = 32'h7777;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #2;
        check("rst_md_busy", md_busy, 0);
        check("rst_atomic", atomic, 0);
        check("rst_cnt", stall_cycles, 0);
        check("rst_stall", stall, 0);
        rst_n = 1;
        step();

        id_valid = 1; fwd_we = 2'b11; fwd_addr = {5'd8, 5'd8};
        fwd_data = {32'h2222, 32'h1111}; fwd_ready = 2'b11;
        id_rs_addr = 8; id_reads_rs = 1; rf_rs_data = 32'hAAAA;
        #1;
        check("prio_rs", rs_data, 32'h1111);
        check("prio_stall", stall, 0);
        step();
        id_rs_addr = 0; rf_rs_data = 32'h55;
        #1;
        check("zero_rs", rs_data, 32'h55);
        check("zero_stall", stall, 0);
        step();
        id_rs_addr = 8; fwd_we = 2'b10;
        #1;
        check("older_rs", rs_data, 32'h2222);
        step();
        fwd_we = 2'b11; fwd_ready = 2'b10;
        #1;
        check("young_notready_stall", stall, 1);
        check("young_notready_rs", rs_data, 32'h1111);
        step();
        check("cnt_1", stall_cycles, 1);

        load_use();
        #1;
        check("lu_stall", stall, 1);
        step();
        check("lu_cnt", stall_cycles, 2);
        fwd_ready = 2'b01;
        #1;
        check("lu_ready_stall", stall, 0);
        check("lu_ready_rt", rt_data, 32'h9999);
        step();
        fwd_ready = 2'b00; id_reads_rt = 0;
        #1;
        check("lu_noread_stall", stall, 0);
        id_reads_rt = 1; id_valid = 0;
        #1;
        check("lu_invalid_stall", stall, 0);
        step();
        check("lu_cnt_hold", stall_cycles, 2);

        clr();
        id_valid = 1; id_is_md = 1;
        #1;
        check("md_issue_stall", stall, 0);
        step();
        clr();
        #1;
        check("md_t1", md_busy, 1);
        step();
        id_valid = 1; id_reads_hilo = 1;
        #1;
        check("mflo_t2_stall", stall, 1);
        check("md_t2", md_busy, 1);
        step();
        check("mflo_t3_stall", stall, 1);
        step();
        check("mflo_t4_stall", stall, 1);
        check("md_t4", md_busy, 1);
        step();
        check("md_t5", md_busy, 0);
        check("mflo_t5_stall", stall, 0);
        check("md_cnt", stall_cycles, 5);
        step();

        clr(); id_valid = 1; id_is_ll = 1;
        #1;
        check("ll_pre_atomic", atomic, 0);
        step();
        clr(); id_valid = 1; id_is_sc = 1;
        #1;
        check("ll_atomic", atomic, 1);
        check("sc_ok_mask", sc_mask, 0);
        step();
        check("sc_clears", atomic, 0);
        check("sc2_mask", sc_mask, 1);
        step();
        clr(); id_valid = 1; id_is_ll = 1;
        step();
        clr(); id_valid = 1; id_is_store = 1;
        #1;
        check("sw_pre_atomic", atomic, 1);
        step();
        clr(); id_valid = 1; id_is_sc = 1;
        #1;
        check("sw_sc_mask", sc_mask, 1);
        check("sw_atomic", atomic, 0);
        step();

        clr(); id_valid = 1; id_is_ll = 1;
        step();
        load_use(); id_is_sc = 1;
        #1;
        check("sc_stalled", stall, 1);
        check("sc_stalled_mask", sc_mask, 0);
        step();
        check("sc_stalled_atomic", atomic, 1);
        check("sc_stalled_cnt", stall_cycles, 6);
        fwd_ready = 2'b01;
        step();
        check("sc_issued_atomic", atomic, 0);

        clr(); id_valid = 1; id_is_ll = 1; flush = 1;
        #1;
        check("ll_flush_stall", stall, 0);
        step();
        check("ll_flush_atomic", atomic, 0);
        clr(); id_valid = 1; id_is_ll = 1;
        step();
        check("ll2_atomic", atomic, 1);
        clr(); flush = 1;
        step();
        check("flush_idle", atomic, 0);
        load_use(); flush = 1;
        #1;
        check("flush_stall", stall, 0);
        step();
        check("flush_cnt", stall_cycles, 6);

        clr(); id_valid = 1; id_is_md = 1;
        step();
        clr(); id_valid = 1; flush = 1;
        step();
        clr();
        #1;
        check("md_after_flush", md_busy, 1);
        step();
        step();
        step();

        load_use();
        for (int i = 0; i < 12; i++) step();
        check("cnt_sat", stall_cycles, 15);

        clr(); id_valid = 1; id_is_md = 1;
        step();
        clr(); id_valid = 1; id_is_ll = 1;
        step();
        clr();
        #1;
        check("pre_rst_md", md_busy, 1);
        check("pre_rst_atomic", atomic, 1);
        check("pre_rst_cnt", stall_cycles, 15);
        rst_n = 0;
        #1;
        check("arst_md", md_busy, 0);
        check("arst_atomic", atomic, 0);
        check("arst_cnt", stall_cycles, 0);
        #3;
        rst_n = 1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
